// File: rtl/shift_deser_pkg.sv
// Shared definitions for the serial deserializer: FSM state encoding and the
// bit-order constants also used by the shift-register transmit side.
package shift_deser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser.sv
// Serial-in/parallel-out deserializer: captures WIDTH bits after a frame strobe,
// in the bit order latched at frame start, and emits the word with a valid pulse.
module shift_deser
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_err
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // Buffer contents after the first bit of a frame, placed where the
    // subsequent shifts will carry it to its final position.
    function automatic logic [WIDTH-1:0] f_first(input logic dir, input logic b);
        logic [WIDTH-1:0] v;
        v = '0;
        if (dir == DIR_LSB_FIRST) v[WIDTH-1] = b;
        else                      v[0]       = b;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] cur,
                                                 input logic dir, input logic b);
        if (dir == DIR_MSB_FIRST) return {cur[WIDTH-2:0], b};
        else                      return {b, cur[WIDTH-1:1]};
    endfunction

    state_t           r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_err;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_first;
    logic             w_last;

    assign w_shifted = f_shift(r_buf, r_dir, i_bit);
    assign w_first   = f_first(i_dir, i_bit);
    assign w_last    = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_MSB_FIRST;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_dir   <= i_dir;
                        r_buf   <= w_first;
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_data  <= w_shifted;
                        r_valid <= 1'b1;
                    end
                    // A strobe on the completion cycle still delivers the old
                    // word; it only counts as an abort if the frame was partial.
                    if (i_start) begin
                        r_dir  <= i_dir;
                        r_buf  <= w_first;
                        r_cnt  <= CNT_W'(1);
                        r_busy <= 1'b1;
                        r_err  <= !w_last;
                    end else if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_buf <= w_shifted;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_err   = r_err;

endmodule

// File: tb/tb_shift_deser.sv
// Scoreboard bench for shift_deser: stimulus queues expected words/aborts with
// their cycle numbers, a negedge monitor pops and compares on each pulse.
module tb_shift_deser;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dir;
    logic         bitin;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } exp_t;

    exp_t vq[$];
    int   eq[$];

    shift_deser #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_dir   (dir),
        .i_bit   (bitin),
        .o_data  (data),
        .o_valid (valid),
        .o_busy  (busy),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every valid/err pulse must match the head of its queue.
    always @(negedge clk) begin : mon
        exp_t e;
        int   ec;
        if (valid === 1'b1) begin
            if (vq.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                e = vq.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("data", 32'(data), 32'(e.data));
            end
        end
        if (err === 1'b1) begin
            if (eq.size() == 0) begin
                chk("unexpected_err", 32'(err), 32'd0);
            end else begin
                ec = eq.pop_front();
                chk("err_cycle", cyc, ec);
            end
        end
    end

    // Drive nbits of a frame starting now; a full frame queues its expected word.
    task automatic send(input logic [W-1:0] word, input logic d, input int nbits,
                        input bit toggle);
        int t0;
        t0 = cyc;
        if (nbits == W) vq.push_back('{t0 + W, word});
        for (int i = 0; i < nbits; i++) begin
            start = (i == 0);
            dir   = (i == 0) ? d : (toggle ? ~d : d);
            bitin = d ? word[i] : word[W-1-i];
            @(posedge clk);
            #1;
            chk("busy", 32'(busy), (i == nbits - 1 && nbits == W) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bitin = 1'($urandom);
            dir   = 1'($urandom);
            @(posedge clk);
            #1;
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        bitin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rst_data", 32'(data), 32'd0);
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            if (i < 5) begin
                @(posedge clk);
                #1;
            end
        end

        send(16'h8888, 1'b0, W, 1'b0);
        idle(3);

        send(16'h1234, 1'b1, W, 1'b1);
        idle(3);

        send(16'hA5A5, 1'b0, W, 1'b0);
        send(16'h0F0F, 1'b1, W, 1'b0);
        idle(3);

        // Abort after 7 bits; the restart strobe carries the new frame's first bit.
        send(16'h5555, 1'b0, 7, 1'b0);
        eq.push_back(cyc + 1);
        send(16'hFFFF, 1'b0, W, 1'b0);
        idle(3);

        // Strobe on the completion cycle: its bit (1) also ends the old frame.
        vq.push_back('{cyc + W, 16'h1235});
        send(16'h1235, 1'b0, W - 1, 1'b0);
        send(16'hC000, 1'b0, W, 1'b0);
        idle(3);

        send(16'h8888, 1'b0, W, 1'b0);
        idle(2);
        chk("pre_rst_data", 32'(data), 32'h8888);
        send(16'h3C3C, 1'b1, 5, 1'b0);
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        idle(2);
        send(16'h0001, 1'b0, W, 1'b0);
        idle(5);

        chk("pending_valid", vq.size(), 32'd0);
        chk("pending_err", eq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-in/parallel-out deserializer; receive end of the 16-bit bidirectional shift register's serial stream.
- Captures WIDTH bits, one per clock, starting on a frame strobe.
- Bit order follows a direction flag latched at frame start.
- Presents the assembled word with a one-cycle valid pulse to downstream logic.

Parameters:
WIDTH, 16, word length in bits (2..32)
CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  synchronous reset, active-high
i_start  input  1  frame strobe; first serial bit is valid on i_bit in the same cycle
i_dir  input  1  bit order, sampled only with i_start: 0 = MSB-first, 1 = LSB-first
i_bit  input  1  serial data bit, sampled every cycle while a frame is active
o_data  output  WIDTH  last completed word; held until the next frame completes
o_valid  output  1  one-cycle pulse: o_data updated this cycle
o_busy  output  1  high while a frame is being received
o_err  output  1  one-cycle pulse: frame aborted by a restart

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE, o_data=0, o_valid=0, o_busy=0, o_err=0, counter=0, shift buffer=0, latched dir=0. Reset wins over every other input in the same cycle.
- States: IDLE, SHIFT.
- IDLE, i_start=1:
  - latch i_dir;
  - load the first bit into the buffer;
  - counter=1;
  - next state SHIFT, or complete immediately only if WIDTH==1 (not supported; WIDTH>=2).
- SHIFT, each cycle:
  - dir=0: buffer <= {buffer[WIDTH-2:0], i_bit}.
  - dir=1: buffer <= {i_bit, buffer[WIDTH-1:1]}.
  - counter increments.
- Completion, on the cycle where counter==WIDTH-1 (i.e. sampling the WIDTH-th bit):
  - o_data <= final shifted value, including that bit;
  - o_valid=1 for the next cycle only;
  - counter=0;
  - next state IDLE.
- Latency: start in cycle 0 → bits sampled in cycles 0..WIDTH-1 → o_valid high in cycle WIDTH.
- Back-to-back frames:
  - i_start is accepted in cycle WIDTH, the same cycle o_valid is high; no idle gap required.
  - o_busy=0 in that cycle, then 1 again.
- o_busy is registered: 1 from cycle 1 through cycle WIDTH-1 of a frame; 0 in IDLE.
- Restart, i_start=1 while in SHIFT:
  - discard the partial buffer;
  - relatch i_dir;
  - treat i_bit as bit 1 of a new frame (counter=1, stay SHIFT);
  - o_err=1 for the next cycle;
  - o_data is unchanged and no o_valid pulse is issued.
- i_start on the completion cycle itself is a restart, not a back-to-back start:
  - the completing frame still updates o_data and pulses o_valid;
  - the new frame begins with counter=1;
  - o_err is not asserted.
- i_dir changing mid-frame has no effect.
- i_bit in IDLE without i_start is ignored.
- Reset mid-frame: the partial frame is dropped and o_data clears to 0 without an o_valid pulse.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package holds:
  - state encoding localparams (ST_IDLE=1'b0, ST_SHIFT=1'b1);
  - direction constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1, common with the shift-register side.
- Single module. No sub-module is needed: the counter and buffer are small enough to stay inline.

Test Plan:
- Reset held 1 cycle, then idle for 5 cycles → o_data=16'h0000, o_valid=0, o_busy=0, o_err=0 throughout.
- i_start with dir=0, serial stream of 16'h8888 MSB-first (1,0,0,0,...) → o_valid high exactly in cycle 16, o_data=16'h8888, o_busy high in cycles 1..15.
- i_start with dir=1, stream of 16'h1234 LSB-first → o_data=16'h1234 in cycle 16. Toggling i_dir mid-frame leaves the result unchanged.
- Back-to-back frames:
  - frame A=16'hA5A5 (dir=0), then i_start in cycle 16 for frame B=16'h0F0F (dir=1);
  - expect o_valid in cycles 16 and 32;
  - expect o_data=16'hA5A5 then 16'h0F0F;
  - expect no o_err.
- Restart:
  - start a frame and send 7 bits, then i_start with a new 16'hFFFF frame;
  - expect o_err pulse in cycle 8;
  - expect no o_valid until 16 cycles after the restart;
  - expect o_data=16'hFFFF.
- Reset mid-frame:
  - complete 16'h8888, start a new frame, assert i_rst at bit 5;
  - expect o_data=0, o_busy=0, no o_valid;
  - a subsequent full frame 16'h0001 completes normally.
